// File: rtl/ram_sized_ctrl.sv
// ram_sized_ctrl: big-endian byte RAM with sized accesses, wait states and mv/moc handshake
//   clk, reset (async, active-high)  | mv request valid, enable chip enable, rw 0=write 1=read
//   type_data 00/01/10/11 = 1/2/4/8 bytes | sign_ext extend reads | address = MSB byte address
//   data_in write data (low bytes) | data_out extended read data | moc complete | err misaligned
module ram_sized_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mv,
  input  logic              enable,
  input  logic              rw,
  input  logic [1:0]        type_data,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [63:0]       data_in,
  output logic [63:0]       data_out,
  output logic              moc,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d, sext_q, sext_d, mis_q, mis_d;
  logic              moc_q, moc_d, err_q, err_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d, dout_q, dout_d;
  logic [63:0]       raw, lowmask, rd_val, wtop;
  logic [6:0]        shift;
  logic [3:0]        nbytes;
  logic              misaligned, we;
  logic [7:0]        mem [2**ADDR_W];
  assign misaligned = (type_data == 2'd1 && address[0]) ||
                      (type_data == 2'd2 && |address[1:0]) ||
                      (type_data == 2'd3 && |address[2:0]);
  assign nbytes  = 4'd1 << type_q;
  // access bytes are kept MSB-justified in a 64-bit lane; shift moves them to/from the LSBs
  assign shift   = 7'd64 - (7'd8 << type_q);
  assign lowmask = ~64'd0 >> shift;
  assign wtop    = wdata_q << shift;
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[63-8*i -: 8] = mem[addr_q + ADDR_W'(i)];
    rd_val = (raw >> shift) | ((sext_q && raw[63]) ? ~lowmask : 64'd0);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    type_d  = type_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    moc_d   = moc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (mv && enable) begin
        // misaligned requests also pass through one BUSY cycle so moc rises one edge after acceptance
        state_d = BUSY;
        cnt_d   = misaligned ? 4'd0 : 4'(WAIT_CYCLES);
        mis_d   = misaligned;
        rw_d    = rw;
        type_d  = type_data;
        sext_d  = sign_ext;
        addr_d  = address;
        wdata_d = data_in;
      end
      BUSY: if (!mv) state_d = IDLE;
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          state_d = DONE;
          moc_d   = 1'b1;
          err_d   = mis_q;
          we      = !mis_q && !rw_q;
          dout_d  = mis_q ? 64'd0 : rw_q ? rd_val : dout_q;
        end
      DONE: if (!mv) begin
        state_d = IDLE;
        moc_d   = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      type_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      type_q  <= type_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end
  // contents survive reset; we is already low while reset holds the FSM in IDLE
  always_ff @(posedge clk) begin
    if (we && !reset)
      for (int i = 0; i < 8; i++)
        if (4'(i) < nbytes) mem[addr_q + ADDR_W'(i)] <= wtop[63-8*i -: 8];
  end
  assign data_out = dout_q;
  assign moc      = moc_q;
  assign err      = err_q;
endmodule

// File: tb/tb_ram_sized_ctrl.sv
// tb_ram_sized_ctrl: directed bench with a transaction-level memory model and per-cycle output compare
module tb_ram_sized_ctrl;
  localparam int W = 2;
  logic        clk = 1'b0;
  logic        reset, mv, enable, rw, sign_ext;
  logic [1:0]  type_data;
  logic [7:0]  address;
  logic [63:0] data_in, data_out;
  logic        moc, err;
  int          checks = 0, errors = 0;
  logic [7:0]  mdl [256];
  logic        exp_moc = 1'b0, exp_err = 1'b0, cmp_en = 1'b0;
  logic [63:0] exp_dout = 64'd0;
  ram_sized_ctrl #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .mv(mv), .enable(enable), .rw(rw),
    .type_data(type_data), .sign_ext(sign_ext), .address(address),
    .data_in(data_in), .data_out(data_out), .moc(moc), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask
  function automatic logic [63:0] mdl_read(input logic [1:0] t, input logic sx, input logic [7:0] a);
    int n = 1 << t;
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(mdl[int'(a) + i]);
    if (sx && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction
  task automatic mdl_write(input logic [1:0] t, input logic [7:0] a, input logic [63:0] d);
    int n = 1 << t;
    for (int i = 0; i < n; i++) mdl[int'(a) + i] = d[8*(n-1-i) +: 8];
  endtask
  always @(negedge clk) if (cmp_en) begin
    chk("moc", 64'(moc), 64'(exp_moc));
    chk("err", 64'(err), 64'(exp_err));
    chk("data_out", data_out, exp_dout);
  end
  // one complete handshake; other inputs are scrambled once accepted to show they are ignored
  task automatic access(input logic r, input logic [1:0] t, input logic sx, input logic [7:0] a,
                        input logic [63:0] d, input int hold);
    int n = 1 << t;
    mv = 1'b1; enable = 1'b1; rw = r; type_data = t; sign_ext = sx; address = a; data_in = d;
    @(posedge clk); #1;
    rw = ~r; type_data = ~t; sign_ext = ~sx; address = a ^ 8'h5a; data_in = ~d; enable = 1'b0;
    if (int'(a) % n == 0) repeat (W) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    exp_moc = 1'b1;
    if (int'(a) % n != 0) begin
      exp_err = 1'b1;
      exp_dout = 64'd0;
    end else begin
      exp_err = 1'b0;
      if (r) exp_dout = mdl_read(t, sx, a);
      else mdl_write(t, a, d);
    end
    repeat (hold) begin @(posedge clk); #1; end
    mv = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    exp_moc = 1'b0; exp_err = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    reset = 1'b1; mv = 1'b0; enable = 1'b0; rw = 1'b0; sign_ext = 1'b0;
    type_data = 2'd0; address = 8'h00; data_in = 64'd0;
    cmp_en = 1'b1;
    #1;
    chk("reset_moc", 64'(moc), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_dout", data_out, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 2'd3, 1'b0, 8'h00, 64'h0011223344556677, 0);
    access(1'b0, 2'd3, 1'b0, 8'h08, 64'h8899aabbccddeeff, 0);
    access(1'b0, 2'd3, 1'b0, 8'h10, 64'h0, 0);
    access(1'b0, 2'd0, 1'b0, 8'h02, 64'h123456789abcde9a, 0);
    access(1'b1, 2'd0, 1'b1, 8'h02, 64'h0, 0);
    chk("t1_byte_sx1", data_out, 64'hffffffffffffff9a);
    access(1'b1, 2'd0, 1'b0, 8'h02, 64'h0, 2);
    chk("t1_byte_sx0", data_out, 64'h000000000000009a);
    access(1'b0, 2'd1, 1'b0, 8'h04, 64'h000000000000bebf, 0);
    access(1'b0, 2'd2, 1'b0, 8'h08, 64'h00000000bebebebf, 0);
    access(1'b1, 2'd0, 1'b0, 8'h04, 64'h0, 0);
    chk("t2_mem4", data_out, 64'h be);
    access(1'b1, 2'd0, 1'b0, 8'h05, 64'h0, 0);
    chk("t2_mem5", data_out, 64'hbf);
    access(1'b1, 2'd0, 1'b0, 8'h0b, 64'h0, 0);
    chk("t2_mem11", data_out, 64'hbf);
    access(1'b1, 2'd2, 1'b1, 8'h08, 64'h0, 0);
    chk("t2_word_sx1", data_out, 64'hffffffffbebebebf);
    access(1'b1, 2'd1, 1'b0, 8'h04, 64'h0, 0);
    chk("t2_half_sx0", data_out, 64'h000000000000bebf);
    access(1'b0, 2'd3, 1'b0, 8'hf8, 64'hcafefeafbebeabee, 0);
    access(1'b1, 2'd3, 1'b1, 8'hf8, 64'h0, 0);
    chk("t3_dword", data_out, 64'hcafefeafbebeabee);
    access(1'b1, 2'd0, 1'b0, 8'hff, 64'h0, 0);
    chk("t3_mem_ff", data_out, 64'hee);
    access(1'b1, 2'd0, 1'b1, 8'hf8, 64'h0, 0);
    chk("t3_mem_f8_sx", data_out, 64'hffffffffffffffca);
    access(1'b0, 2'd2, 1'b0, 8'h06, 64'hdeadbeefdeadbeef, 1);
    chk("t4_dout_zero", data_out, 64'd0);
    access(1'b1, 2'd1, 1'b0, 8'h06, 64'h0, 0);
    chk("t4_mem67", data_out, 64'h6677);
    access(1'b1, 2'd2, 1'b0, 8'h08, 64'h0, 0);
    chk("t4_mem8_11", data_out, 64'h00000000bebebebf);
    access(1'b1, 2'd1, 1'b0, 8'h05, 64'h0, 0);
    access(1'b1, 2'd3, 1'b0, 8'h04, 64'h0, 2);
    // abort one cycle into BUSY
    mv = 1'b1; enable = 1'b1; rw = 1'b0; type_data = 2'd0; address = 8'h03; data_in = 64'h77;
    @(posedge clk); #1;
    mv = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    // abort on the edge that would have performed the write
    mv = 1'b1; enable = 1'b1; rw = 1'b0; type_data = 2'd0; address = 8'h03; data_in = 64'h44;
    @(posedge clk); #1;
    repeat (W) begin @(posedge clk); #1; end
    mv = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    access(1'b1, 2'd0, 1'b0, 8'h03, 64'h0, 0);
    chk("t5a_mem3", data_out, 64'h33);
    mv = 1'b1; enable = 1'b0; rw = 1'b0; type_data = 2'd0; address = 8'h02; data_in = 64'h11;
    repeat (4) begin @(posedge clk); #1; end
    mv = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 2'd0, 1'b0, 8'h02, 64'h0, 0);
    chk("t5b_mem2", data_out, 64'h9a);
    mv = 1'b1; enable = 1'b1; rw = 1'b0; type_data = 2'd0; address = 8'h10; data_in = 64'h55;
    @(posedge clk); #1;
    #2;
    reset = 1'b1;
    exp_moc = 1'b0; exp_err = 1'b0; exp_dout = 64'd0;
    #1;
    chk("t6_moc", 64'(moc), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_dout", data_out, 64'd0);
    mv = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 2'd0, 1'b0, 8'h10, 64'h0, 0);
    chk("t6_mem10", data_out, 64'h00);
    access(1'b0, 2'd0, 1'b0, 8'h10, 64'h55, 0);
    access(1'b1, 2'd0, 1'b0, 8'h10, 64'h0, 0);
    chk("t6_mem10_new", data_out, 64'h55);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
